// File: rtl/instr_mem.sv
// instr_mem: clocked instruction memory with a valid/ready fetch port,
// a run-time program-load port and a power-up clear sequencer.
// Optional macro IMEM_PARITY_EN: each word stores one even-parity bit and
// parity_err flags a mismatch on the response beat. Without it, parity_err
// is tied low.
// rst_n asserts asynchronously. Its release is expected to be already
// synchronous to clk, so INIT starts on the first edge after release.
//
// state | meaning
// ------+-----------------------------------------------
// INIT  | clearing word[cnt] to NOP, one word per cycle
// RUN   | fetch and load ports active; left only by reset
module instr_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_oob,
    input  logic              fetch_take,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ack,
    output logic              init_busy,
    output logic              parity_err
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              fetch_acc;
    logic              fetch_hit;
    logic              load_hit;
    logic [CNT_W-1:0]  fetch_idx;
    logic [CNT_W-1:0]  load_idx;

    // Range checks use the full address; only the low bits index the array.
    assign fetch_hit = {1'b0, fetch_addr} < DEPTH_X;
    assign load_hit  = {1'b0, load_addr} < DEPTH_X;
    assign fetch_idx = fetch_addr[CNT_W-1:0];
    assign load_idx  = load_addr[CNT_W-1:0];
    assign fetch_acc = fetch_req && fetch_ready;

    // State register and clear counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, clear-counter advance and handshake outputs.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        init_busy   = 1'b0;
        fetch_ready = 1'b0;
        case (state)
            ST_INIT: begin
                init_busy = 1'b1;
                cnt_nxt   = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                fetch_ready = !fetch_valid || fetch_take;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Array write port: clear during INIT, program loads during RUN.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[cnt] <= '0;
        end else if (load_en && load_hit) begin
            mem[load_idx] <= load_data;
        end
    end

    // Response beat; the array read sees the pre-edge contents, so a
    // same-cycle load to the fetched address returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            fetch_oob   <= 1'b0;
        end else if (fetch_acc) begin
            fetch_valid <= 1'b1;
            fetch_instr <= fetch_hit ? mem[fetch_idx] : '0;
            fetch_oob   <= !fetch_hit;
        end else if (fetch_take) begin
            fetch_valid <= 1'b0;
        end
    end

    // Load acknowledge, one cycle after any load seen in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_ack <= 1'b0;
        end else begin
            load_ack <= (state == ST_RUN) && load_en;
        end
    end

`ifdef IMEM_PARITY_EN
    logic mem_par [DEPTH];
    logic par_err_q;

    // Parity column write port, mirrors the data array writes.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem_par[cnt] <= 1'b0;
        end else if (load_en && load_hit) begin
            mem_par[load_idx] <= ^load_data;
        end
    end

    // Parity check result, held with the beat and cleared when it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if (fetch_acc) begin
            par_err_q <= fetch_hit && ((^mem[fetch_idx]) ^ mem_par[fetch_idx]);
        end else if (fetch_take) begin
            par_err_q <= 1'b0;
        end
    end

    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed scenarios plus random traffic
// against a reference array model, with a scoreboard queue for response beats.
module tb_instr_mem;

    localparam int DEPTH = 256;

    typedef struct packed {
        logic [15:0] instr;
        logic        oob;
        logic        perr;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [15:0] fetch_instr;
    logic        fetch_oob;
    logic        fetch_take = 1'b0;
    logic        load_en = 1'b0;
    logic [15:0] load_addr = '0;
    logic [15:0] load_data = '0;
    logic        load_ack;
    logic        init_busy;
    logic        parity_err;

    instr_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_oob  (fetch_oob),
        .fetch_take (fetch_take),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ack   (load_ack),
        .init_busy  (init_busy),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] ref_mem [DEPTH];
    bit          ref_bad [DEPTH];
    beat_t       sb_q[$];
    logic        m_valid = 1'b0;
    logic        exp_ack = 1'b0;
    int          init_cnt = 0;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 16'($urandom_range(DEPTH, 65535));
        return 16'($urandom_range(0, DEPTH - 1));
    endfunction

    // Called at a falling edge: assert reset off-edge, check async values,
    // reset the model, release on the next falling edge.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        fetch_req = 1'b0; fetch_take = 1'b0; load_en = 1'b0;
        #1;
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_fetch_instr", fetch_instr, 0);
        chk("rst_fetch_oob", fetch_oob, 0);
        chk("rst_load_ack", load_ack, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_init_busy", init_busy, 1);
        chk("rst_fetch_ready", fetch_ready, 0);
        sb_q.delete();
        m_valid = 1'b0;
        exp_ack = 1'b0;
        init_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 16'h0000;
            ref_bad[i] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus, driven at the falling edge.
    task automatic cycle(input logic req, input logic [15:0] fa, input logic take,
                         input logic ld, input logic [15:0] la, input logic [15:0] ldat);
        logic  run, exp_ready, acc;
        beat_t b;
        fetch_req = req; fetch_addr = fa; fetch_take = take;
        load_en = ld; load_addr = la; load_data = ldat;
        #1;
        run = (init_cnt >= DEPTH);
        exp_ready = run && (!m_valid || take);
        chk("init_busy", init_busy, 32'(!run));
        chk("fetch_ready", fetch_ready, 32'(exp_ready));
        chk("fetch_valid", fetch_valid, 32'(m_valid));
        chk("load_ack", load_ack, 32'(exp_ack));
        if (!m_valid) chk("parity_idle", parity_err, 0);
        acc = req && exp_ready;
        if (acc) begin
            if (int'(fa) >= DEPTH) begin
                b.instr = 16'h0000; b.oob = 1'b1; b.perr = 1'b0;
            end else begin
                b.instr = ref_mem[int'(fa)]; b.oob = 1'b0; b.perr = ref_bad[int'(fa)];
            end
            sb_q.push_back(b);
        end
        if (run && ld && int'(la) < DEPTH) begin
            ref_mem[int'(la)] = ldat;
            ref_bad[int'(la)] = 1'b0;
        end
        exp_ack = run && ld;
        if (acc) m_valid = 1'b1;
        else if (take) m_valid = 1'b0;
        @(posedge clk);
        if (init_cnt < DEPTH) init_cnt++;
        @(negedge clk);
    endtask

    task automatic idle(input logic take);
        cycle(1'b0, 16'h0, take, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), rand_addr(), 16'($urandom));
        end
    endtask

    // Monitor: compare the presented beat with the scoreboard head each cycle
    // (repeated compares cover hold stability), pop when the beat is taken.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && fetch_valid) begin
                chk("beat_expected", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    chk("fetch_instr", fetch_instr, sb_q[0].instr);
                    chk("fetch_oob", fetch_oob, sb_q[0].oob);
                    chk("parity_err", parity_err, sb_q[0].perr);
                    if (fetch_take) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        do_reset();

        // INIT with fetch held and random loads that must be ignored.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 16'($urandom_range(0, DEPTH - 1)), 1'b1,
                  1'($urandom_range(0, 1)), 16'($urandom_range(0, DEPTH - 1)), 16'($urandom));
        end
        cycle(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0, 16'h0);
        idle(1'b1);

        // Program load then back-to-back fetches.
        cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0000, 16'h0490);
        cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0001, 16'h0521);
        cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0002, 16'h05B3);
        cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0003, 16'hC4A0);
        for (int a = 0; a < 4; a++) cycle(1'b1, 16'(a), 1'b1, 1'b0, 16'h0, 16'h0);
        idle(1'b1);

        // Back-pressure: hold the beat for three cycles.
        cycle(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(1'b1);
        idle(1'b1);

        // Out-of-range fetch and load (0x0100 aliases word 0 in the low bits).
        cycle(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0, 16'h0);
        cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0100, 16'h1234);
        cycle(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0, 16'h0);
        cycle(1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0, 16'h0);
        idle(1'b1);

        // Same-cycle fetch and load to one address: old word first, then new.
        cycle(1'b1, 16'h0002, 1'b1, 1'b1, 16'h0002, 16'hFFFF);
        cycle(1'b1, 16'h0002, 1'b1, 1'b0, 16'h0, 16'h0);
        idle(1'b1);

`ifdef IMEM_PARITY_EN
        dut.mem_par[3] = ~dut.mem_par[3];
        ref_bad[3] = 1'b1;
        cycle(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0, 16'h0);
        cycle(1'b1, 16'h0004, 1'b1, 1'b0, 16'h0, 16'h0);
        idle(1'b1);
`endif

        rand_cycles(1500);

        // Reset with a beat held.
        idle(1'b1);
        cycle(1'b1, 16'h0007, 1'b1, 1'b0, 16'h0, 16'h0);
        idle(1'b0);
        do_reset();

        // Reset mid-INIT at count 100, then a full INIT.
        rand_cycles(100);
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, rand_addr(), 1'b1, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
        end
        rand_cycles(300);
        idle(1'b1);
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_mem.md
Name: instr_mem

Overview:
Parametrised, synchronous instruction memory that replaces the fixed combinational ROM with a clocked fetch port and a program-load port.
- After reset, a built-in init sequencer clears the array to NOP (all zeros).
- The CPU fetch stage reads through a valid/ready handshake with 1-cycle latency and back-pressure.
- A loader (debug or boot path) writes program words at run time.

Parameters:
DATA_W, 16, instruction width in bits
ADDR_W, 16, fetch/load address width
DEPTH, 256, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W
CNT_W, $clog2(DEPTH), init-counter width (derived localparam, not overridable)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W  word address of the request
fetch_ready  out  1  request accepted this cycle when fetch_req && fetch_ready
fetch_valid  out  1  response beat present
fetch_instr  out  DATA_W  instruction word of the response beat
fetch_oob  out  1  response beat was for an address >= DEPTH
fetch_take  in  1  consumer accepts the response beat this cycle
load_en  in  1  write strobe, one word per cycle
load_addr  in  ADDR_W  write address
load_data  in  DATA_W  write data
load_ack  out  1  one-cycle pulse, the cycle after an accepted load
init_busy  out  1  clear sequence in progress
parity_err  out  1  parity mismatch on the response beat (see Optional Feature)

Behaviour:
- Reset (async assert, sync release to the clk domain by the top level):
  - state=INIT, init counter=0.
  - fetch_valid=0, fetch_instr=0, fetch_oob=0, load_ack=0, parity_err=0, init_busy=1.
  - Array contents are not flop-reset; they are cleared by INIT.
- State INIT:
  - Writes 0 to word[cnt] each cycle; cnt increments 0..DEPTH-1.
  - After the write of DEPTH-1, goes to RUN. INIT therefore lasts exactly DEPTH cycles.
  - init_busy=1, fetch_ready=0.
  - load_en is ignored: no write, no ack.
- State RUN: init_busy=0. RUN is left only by reset.
- Fetch handshake:
  - fetch_ready = RUN && (!fetch_valid || fetch_take).
  - Accept at edge N -> at edge N+1: fetch_valid=1, fetch_instr=word[fetch_addr], fetch_oob=0.
  - If fetch_addr >= DEPTH: fetch_instr=0 (NOP), fetch_oob=1.
  - While fetch_valid && !fetch_take, fetch_instr, fetch_oob and parity_err hold stable.
  - fetch_take with no new accept -> fetch_valid=0 next cycle.
  - Take plus accept in the same cycle -> back-to-back beats, one instruction per clock.
  - fetch_take while !fetch_valid is ignored.
- Load:
  - load_en in RUN writes word[load_addr]=load_data at the edge; load_ack=1 for the next cycle only.
  - load_addr >= DEPTH: write dropped, load_ack still pulses.
  - Loads are never stalled, and they have priority over nothing: fetch and load proceed in the same cycle.
- Collision, accepted fetch and load to the same address in the same cycle: the response carries the OLD word (read-before-write). The next fetch sees the new word.
- Address compare uses the full ADDR_W. Only the low CNT_W bits index the array.
- Reset asserted mid-INIT or mid-beat: immediate return to the reset values above; INIT restarts from word 0.

Optional Feature:
Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed on every write; INIT writes parity 0.
  - On each response beat, parity_err = (XOR of stored data and stored parity bit) != 0. It is held with the beat and is 0 when fetch_valid=0.
- Not defined: no parity storage; parity_err tied to 0.

Test Plan:
1. Release rst_n, hold fetch_req=1 -> init_busy=1 and fetch_ready=0 for exactly DEPTH (256) cycles. First accept follows, and a fetch of 0x0003 returns 0x0000.
2. Load 0x0490, 0x0521, 0x05B3, 0xC4A0 to addresses 0..3 -> load_ack pulses once per write. Back-to-back fetches 0..3 with fetch_take=1 return those four words on four consecutive cycles.
3. Fetch addr 1, hold fetch_take=0 for 3 cycles -> fetch_valid=1, fetch_instr=0x0521 stable, fetch_ready=0. Take -> fetch_ready=1 in the same cycle.
4. Fetch 0x0100 (DEPTH=256) -> fetch_instr=0x0000, fetch_oob=1. Load to 0x0100 -> load_ack=1, array unchanged.
5. Same-cycle fetch and load of addr 2 with data 0xFFFF -> response 0x05B3. Next fetch of addr 2 -> 0xFFFF.
6. Assert rst_n=0 at INIT count 100 -> outputs return to reset values asynchronously. After release, INIT takes the full 256 cycles. With IMEM_PARITY_EN, force a stored parity bit flip -> parity_err=1 on that beat only.
